// File: rtl/maria_vga_out.sv
// MARIA downstream video stage: 640x480@60 raster counters, UV-to-RGB palette lookup,
// and sync/blank/frame_start outputs aligned to RGB two cycles after vga_col/vga_row.
module maria_vga_out #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       vidclk,
  input  logic       reset,
  output logic [9:0] vga_col,
  output logic [9:0] vga_row,
  input  logic [7:0] UV_in,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Sync flags travel active-high internally; polarity is applied at the output register.
  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
    logic frame_start;
  } flags_t;

  localparam flags_t FLAGS_IDLE = '{hblank: 1'b1, vblank: 1'b1, hsync: 1'b0,
                                    vsync: 1'b0, frame_start: 1'b0};

  function automatic logic [11:0] hue_base(input logic [3:0] hue);
    case (hue)
      4'd1:    hue_base = 12'hFD0;
      4'd2:    hue_base = 12'hFB0;
      4'd3:    hue_base = 12'hF80;
      4'd4:    hue_base = 12'hF55;
      4'd5:    hue_base = 12'hF5B;
      4'd6:    hue_base = 12'hC5F;
      4'd7:    hue_base = 12'h85F;
      4'd8:    hue_base = 12'h55F;
      4'd9:    hue_base = 12'h5AF;
      4'd10:   hue_base = 12'h5DF;
      4'd11:   hue_base = 12'h5FD;
      4'd12:   hue_base = 12'h5F8;
      4'd13:   hue_base = 12'h6F5;
      4'd14:   hue_base = 12'hAF4;
      4'd15:   hue_base = 12'hDE4;
      default: hue_base = 12'hFFF;
    endcase
  endfunction

  function automatic logic [3:0] chan(input logic [3:0] c, input int scale);
    return 4'((int'(c) * scale) / 16);
  endfunction

  // Hue 0 is exact greyscale; other hues scale the NTSC hue base by luma + 1.
  function automatic logic [256*12-1:0] build_palette();
    logic [256*12-1:0] p;
    logic [11:0]       base;
    int                scale;
    p = '0;
    for (int u = 0; u < 256; u++) begin
      scale = (u % 16) + 1;
      if (u < 16) begin
        p[u*12 +: 12] = {3{4'(u)}};
      end else begin
        base = hue_base(4'(u / 16));
        p[u*12 +: 12] = {chan(base[11:8], scale), chan(base[7:4], scale),
                         chan(base[3:0], scale)};
      end
    end
    return p;
  endfunction

  localparam logic [256*12-1:0] PALETTE = build_palette();

  logic [11:0] rom [256];
  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = PALETTE[i*12 +: 12];
  end

  flags_t raw;
  flags_t s1;

  always_comb begin
    raw.hblank      = vga_col >= H_VIS;
    raw.vblank      = vga_row >= V_VIS;
    raw.hsync       = (vga_col >= HS_BEGIN) && (vga_col < HS_END);
    raw.vsync       = (vga_row >= VS_BEGIN) && (vga_row < VS_END);
    raw.frame_start = (vga_col == 10'd0) && (vga_row == 10'd0);
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values and the pipeline stages stay exactly one cycle apart.
  always_ff @(posedge vidclk) begin
    if (reset) begin
      vga_col <= '0;
      vga_row <= '0;
    end else if (vga_col == H_LAST) begin
      vga_col <= '0;
      vga_row <= (vga_row == V_LAST) ? 10'd0 : vga_row + 10'd1;
    end else begin
      vga_col <= vga_col + 10'd1;
    end
  end

  // UV_in for the stage-1 coordinates arrives during stage 1, so the ROM read is the
  // stage-2 register; blanking is applied from the stage-1 flags at the same edge.
  always_ff @(posedge vidclk) begin
    if (reset) begin
      s1          <= FLAGS_IDLE;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      s1          <= raw;
      hblank      <= s1.hblank;
      vblank      <= s1.vblank;
      hsync       <= s1.hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= s1.vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start <= s1.frame_start;
      if (s1.hblank || s1.vblank) {red, green, blue} <= '0;
      else                        {red, green, blue} <= rom[UV_in];
    end
  end

endmodule

// File: tb/tb_maria_vga_out.sv
// Directed bench for maria_vga_out: a default 640x480 instance for line timing and pixel
// alignment, and a reduced-raster instance (32x15, active-high sync) for frame timing.
module tb_maria_vga_out;

  logic       vidclk = 1'b0;
  logic       reset;
  logic [7:0] uv_d, uv_s;
  logic [9:0] d_col, d_row, s_col, s_row;
  logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;
  logic       d_hs, d_vs, d_hb, d_vb, d_fs;
  logic       s_hs, s_vs, s_hb, s_vb, s_fs;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 vidclk = ~vidclk;

  maria_vga_out dut (
    .vidclk(vidclk), .reset(reset), .vga_col(d_col), .vga_row(d_row), .UV_in(uv_d),
    .red(d_r), .green(d_g), .blue(d_b), .hsync(d_hs), .vsync(d_vs),
    .hblank(d_hb), .vblank(d_vb), .frame_start(d_fs)
  );

  maria_vga_out #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b1)
  ) dut_s (
    .vidclk(vidclk), .reset(reset), .vga_col(s_col), .vga_row(s_row), .UV_in(uv_s),
    .red(s_r), .green(s_g), .blue(s_b), .hsync(s_hs), .vsync(s_vs),
    .hblank(s_hb), .vblank(s_vb), .frame_start(s_fs)
  );

  // Packed view {hblank, vblank, hsync, vsync, frame_start, r, g, b}.
  localparam logic [16:0] RST_D = 17'h1E000;
  localparam logic [16:0] RST_S = 17'h18000;

  function automatic logic [16:0] obs_d();
    return {d_hb, d_vb, d_hs, d_vs, d_fs, d_r, d_g, d_b};
  endfunction

  function automatic logic [16:0] obs_s();
    return {s_hb, s_vb, s_hs, s_vs, s_fs, s_r, s_g, s_b};
  endfunction

  // Reference raster model: expected outputs for a pixel; coloured (hue != 0) pixels
  // only need to be nonzero, so their RGB is masked out and flagged instead.
  function automatic void exp_of(input int c, input int r, input logic [7:0] uv,
                                 input int hv, input int hss, input int hse,
                                 input int vv, input int vss, input int vse,
                                 input logic sa, output logic [16:0] e,
                                 output logic [16:0] m, output logic nz);
    logic hb, vb;
    hb = (c >= hv);
    vb = (r >= vv);
    e[16] = hb;
    e[15] = vb;
    e[14] = (c >= hss && c < hse) ? sa : ~sa;
    e[13] = (r >= vss && r < vse) ? sa : ~sa;
    e[12] = (c == 0 && r == 0);
    m  = 17'h1FFFF;
    nz = 1'b0;
    if (hb || vb)              e[11:0] = 12'h000;
    else if (uv[7:4] == 4'h0)  e[11:0] = {uv[3:0], uv[3:0], uv[3:0]};
    else begin
      e[11:0] = 12'h000;
      m       = 17'h1F000;
      nz      = 1'b1;
    end
  endfunction

  int          md_col, md_row, md_c1, md_r1, ms_col, ms_row, ms_c1, ms_r1;
  logic        md_v1, ms_v1, md_nz, ms_nz;
  logic [16:0] md_e, md_m, ms_e, ms_m;
  logic        uv_mode;
  logic [7:0]  uv_const;

  task automatic step();
    logic [7:0] uvd_now, uvs_now;
    int         pcol;
    uvd_now = uv_d;
    uvs_now = uv_s;
    pcol    = md_col;
    @(posedge vidclk);
    #1;
    cyc++;
    if (reset) begin
      md_col = 0; md_row = 0; md_v1 = 1'b0; md_e = RST_D; md_m = '1; md_nz = 1'b0;
      ms_col = 0; ms_row = 0; ms_v1 = 1'b0; ms_e = RST_S; ms_m = '1; ms_nz = 1'b0;
    end else begin
      if (md_v1) exp_of(md_c1, md_r1, uvd_now, 640, 656, 752, 480, 490, 492, 1'b0,
                        md_e, md_m, md_nz);
      else begin md_e = RST_D; md_m = '1; md_nz = 1'b0; end
      if (ms_v1) exp_of(ms_c1, ms_r1, uvs_now, 16, 20, 26, 8, 10, 12, 1'b1,
                        ms_e, ms_m, ms_nz);
      else begin ms_e = RST_S; ms_m = '1; ms_nz = 1'b0; end
      md_v1 = 1'b1; md_c1 = md_col; md_r1 = md_row;
      ms_v1 = 1'b1; ms_c1 = ms_col; ms_r1 = ms_row;
      if (md_col == 799) begin md_col = 0; md_row = (md_row == 524) ? 0 : md_row + 1; end
      else md_col++;
      if (ms_col == 31) begin ms_col = 0; ms_row = (ms_row == 14) ? 0 : ms_row + 1; end
      else ms_col++;
    end
    uv_d = uv_mode ? {4'h0, 4'(pcol)} : uv_const;
  endtask

  // Checks the three post-release cycles: blank at R+2, first pixel and frame_start at R+3.
  task automatic test_reset_release(input string tag);
    logic [16:0] o;
    reset = 1'b0;
    step();
    checks++;
    if (d_col !== 10'd1 || obs_d() !== RST_D || obs_s() !== RST_S) begin
      errors++;
      $display("FAIL %s_r2 col=%0d out=%h/%h want col=1 out=%h/%h", tag, d_col,
               obs_d(), obs_s(), RST_D, RST_S);
    end
    step();
    checks++;
    if (d_col !== 10'd2 || obs_d() !== 17'h07FFF) begin
      errors++;
      $display("FAIL %s_r3_d col=%0d out=%h want col=2 out=07fff", tag, d_col, obs_d());
    end
    o = obs_s();
    checks++;
    if (o[16:12] !== 5'b00001 || o[11:0] == 12'h000) begin
      errors++;
      $display("FAIL %s_r3_s out=%h want flags 01 and nonzero rgb", tag, o);
    end
    step();
    checks++;
    if (d_col !== 10'd3 || d_fs !== 1'b0 || s_fs !== 1'b0) begin
      errors++;
      $display("FAIL %s_r4 col=%0d fs=%b/%b want col=3 fs=0/0", tag, d_col, d_fs, s_fs);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; uv_mode = 1'b0; uv_const = 8'h0F; uv_d = 8'h0F;
    repeat (3) step();
    checks++;
    if (d_col !== 10'd0 || d_row !== 10'd0 || s_col !== 10'd0 || s_row !== 10'd0) begin
      errors++;
      $display("FAIL reset_cnt d=%0d,%0d s=%0d,%0d want 0,0", d_col, d_row, s_col, s_row);
    end
    checks++;
    if (obs_d() !== RST_D || obs_s() !== RST_S) begin
      errors++;
      $display("FAIL reset_out got %h/%h want %h/%h", obs_d(), obs_s(), RST_D, RST_S);
    end
    test_reset_release("rst");
  endtask

  task automatic test_greyscale();
    logic [7:0] vals [3] = '{8'h0F, 8'h00, 8'h07};
    logic [3:0] want [3] = '{4'hF, 4'h0, 4'h7};
    uv_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      uv_const = vals[i];
      uv_d     = vals[i];
      repeat (2) step();
      checks++;
      if (d_r !== want[i] || d_g !== want[i] || d_b !== want[i] || d_hb !== 1'b0) begin
        errors++;
        $display("FAIL grey_%h rgb=%h%h%h hb=%b want %h%h%h hb=0", vals[i], d_r, d_g,
                 d_b, d_hb, want[i], want[i], want[i]);
      end
    end
  endtask

  task automatic test_pipeline();
    logic [16:0] o;
    logic        prev_hs, saw_fall;
    int          low;
    uv_mode  = 1'b1;
    prev_hs  = d_hs;
    saw_fall = 1'b0;
    low      = 0;
    for (int i = 0; i < 1700; i++) begin
      step();
      o = obs_d();
      checks++;
      if ({d_col, d_row} !== {10'(md_col), 10'(md_row)} || (o & md_m) !== (md_e & md_m)) begin
        errors++;
        $display("FAIL pipe col=%0d row=%0d got %0d,%0d %h want %h", md_col, md_row,
                 d_col, d_row, o, md_e);
      end
      if (i >= 3 && md_col >= 2 && md_col < 642) begin
        checks++;
        if (d_r !== 4'(md_col - 2) || d_b !== 4'(md_col - 2)) begin
          errors++;
          $display("FAIL align col=%0d rgb=%h%h%h want grey %h", md_col, d_r, d_g, d_b,
                   4'(md_col - 2));
        end
      end
      if (prev_hs && !d_hs) begin
        checks++;
        if (md_col != 658) begin
          errors++;
          $display("FAIL hsync_start at col=%0d want 658", md_col);
        end
        saw_fall = 1'b1;
        low      = 0;
      end
      if (!d_hs) low++;
      if (!prev_hs && d_hs && saw_fall) begin
        checks++;
        if (low != 96) begin
          errors++;
          $display("FAIL hsync_width got %0d want 96", low);
        end
      end
      prev_hs = d_hs;
    end
  endtask

  task automatic test_blank_ff();
    logic [16:0] o;
    int          lit;
    uv_mode = 1'b0; uv_const = 8'hFF; uv_d = 8'hFF;
    repeat (2) step();
    lit = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      o = obs_d();
      if (o[11:0] != 12'h000) lit++;
      checks++;
      if ((o & md_m) !== (md_e & md_m) || (md_nz && o[11:0] == 12'h000)) begin
        errors++;
        $display("FAIL blank col=%0d row=%0d got %h want %h", md_col, md_row, o, md_e);
      end
    end
    checks++;
    if (lit != 640) begin
      errors++;
      $display("FAIL blank_count lit pixels %0d want 640", lit);
    end
  endtask

  task automatic test_frame();
    logic [16:0] o;
    int          waited, fs_cnt, vs_cnt, fs_at;
    waited = 0;
    while (s_fs !== 1'b1 && waited < 600) begin step(); waited++; end
    checks++;
    if (s_fs !== 1'b1) begin
      errors++;
      $display("FAIL frame_wait no frame_start within %0d cycles", waited);
    end
    fs_cnt = 0; vs_cnt = 0; fs_at = 0;
    for (int i = 1; i <= 960; i++) begin
      step();
      o = obs_s();
      if (s_vs) vs_cnt++;
      if (s_fs) begin
        fs_cnt++;
        checks++;
        if (i != 480 * fs_cnt) begin
          errors++;
          $display("FAIL frame_period pulse at %0d want %0d", i, 480 * fs_cnt);
        end
        fs_at = i;
      end
      checks++;
      if ({s_col, s_row} !== {10'(ms_col), 10'(ms_row)} || (o & ms_m) !== (ms_e & ms_m) ||
          (ms_nz && o[11:0] == 12'h000)) begin
        errors++;
        $display("FAIL frame col=%0d row=%0d got %0d,%0d %h want %h", ms_col, ms_row,
                 s_col, s_row, o, ms_e);
      end
    end
    checks++;
    if (fs_cnt != 2 || vs_cnt != 128 || fs_at != 960) begin
      errors++;
      $display("FAIL frame_counts fs=%0d vs=%0d last=%0d want 2 128 960", fs_cnt, vs_cnt,
               fs_at);
    end
  endtask

  task automatic test_midframe_reset();
    logic [16:0] o;
    int          waited;
    uv_mode = 1'b1;
    waited  = 0;
    while (md_col != 300 && waited < 900) begin step(); waited++; end
    checks++;
    if (md_col != 300) begin
      errors++;
      $display("FAIL mid_wait col %0d want 300", md_col);
    end
    reset = 1'b1;
    uv_mode = 1'b0; uv_const = 8'h0F; uv_d = 8'h0F;
    step();
    checks++;
    if ({d_col, d_row, s_col, s_row} !== 40'd0 || obs_d() !== RST_D || obs_s() !== RST_S) begin
      errors++;
      $display("FAIL mid_reset cnt=%0d,%0d out=%h/%h want 0,0 %h/%h", d_col, d_row,
               obs_d(), obs_s(), RST_D, RST_S);
    end
    test_reset_release("mid");
    uv_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      o = obs_d();
      checks++;
      if ({d_col, d_row} !== {10'(md_col), 10'(md_row)} || (o & md_m) !== (md_e & md_m)) begin
        errors++;
        $display("FAIL mid_resume col=%0d got %0d %h want %h", md_col, d_col, o, md_e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    uv_mode = 1'b0; uv_const = 8'h00; uv_d = 8'h00; uv_s = 8'hFF;
    md_col = 0; md_row = 0; md_c1 = 0; md_r1 = 0; md_v1 = 1'b0;
    ms_col = 0; ms_row = 0; ms_c1 = 0; ms_r1 = 0; ms_v1 = 1'b0;
    md_e = RST_D; md_m = '1; md_nz = 1'b0;
    ms_e = RST_S; ms_m = '1; ms_nz = 1'b0;
    test_reset();
    test_greyscale();
    test_pipeline();
    test_blank_ff();
    test_frame();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
